seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_sub.sv | 18 +
 rtl/seq_divider.sv | 119 +++++++++++
 tb/tb_seq_divider.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared divider constants: FSM encodings, iteration count, divide-by-zero quotient.
package seq_divider_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int              DIV_ITER   = 32;
  localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 32'd1) : x;
  endfunction
endpackage

// File: rtl/seq_divider_sub.sv
// 32-bit ripple-borrow subtractor: result = a - b, cout = borrow out (a < b).
module sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        cout
);
  always_comb begin
    logic bw;
    bw     = 1'b0;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      result[i] = a[i] ^ b[i] ^ bw;
      bw        = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    cout = bw;
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define SIGNED_DIV_EN to honour op_signed; otherwise every op is unsigned.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] q_work, r_work, d_work;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] trial_a, diff, r_next, q_next;
  logic             borrow, ok;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             sgn_a, sgn_b, ovf;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // R[31] set means the true 33-bit partial remainder already exceeds D.
  assign trial_a = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
  assign ok      = r_work[WIDTH-1] | ~borrow;
  assign r_next  = ok ? diff : trial_a;
  assign q_next  = {q_work[WIDTH-2:0], ok};

  sub u_sub (
    .a      (trial_a),
    .b      (d_work),
    .result (diff),
    .cout   (borrow)
  );

`ifdef SIGNED_DIV_EN
  assign sgn_a = op_signed & dividend[WIDTH-1];
  assign sgn_b = op_signed & divisor[WIDTH-1];
  assign abs_a = neg_if(dividend, sgn_a);
  assign abs_b = neg_if(divisor, sgn_b);
  assign ovf   = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
  assign sgn_a = 1'b0;
  assign sgn_b = 1'b0;
  assign abs_a = dividend;
  assign abs_b = divisor;
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      q_work    <= '0;
      r_work    <= '0;
      d_work    <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          q_work <= abs_a;
          d_work <= abs_b;
          r_work <= '0;
          cnt    <= '0;
          neg_q  <= sgn_a ^ sgn_b;
          neg_r  <= sgn_a;
          if (divisor == '0) begin
            quotient  <= DIV_ZERO_Q;
            remainder <= dividend;
            state     <= S_DONE;
          end else if (ovf) begin
            quotient  <= 32'h8000_0000;
            remainder <= '0;
            state     <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          q_work <= q_next;
          r_work <= r_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
`ifdef SIGNED_DIV_EN
            quotient  <= neg_if(q_next, neg_q);
            remainder <= neg_if(r_next, neg_r);
`else
            quotient  <= q_next;
            remainder <= r_next;
`endif
            state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SIGNED_DIV_EN
  logic unused_signs;
  assign unused_signs = neg_q ^ neg_r;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// Directed + random bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend, divisor;
  logic        op_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

`ifdef SIGNED_DIV_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .op_signed (op_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    lat = 33;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (SGN && s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; lat = 1;
    end else if (SGN && s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Entry/exit: #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [31:0] eq, er;
    int elat, lat;
    model(a, b, s, eq, er, elat);
    dividend  = a;
    divisor   = b;
    op_signed = s;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("latency", lat, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    for (int i = 0; i < hold; i++) begin
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_q", quotient, eq);
      check("hold_r", remainder, er);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    if (hold > 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; op_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b1, 0);
    run_op(-32'sd7, 32'd2, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd1000, 32'd33, 1'b0, 10);
    run_op(32'd12, 32'd4, 1'b0, 0);

    // Reset in the middle of an iteration sequence discards the partial result.
    dividend = 32'd1_000_000; divisor = 32'd3; op_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, 0);

    for (int n = 0; n < 25; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
